// File: rtl/pc_unit_if.sv
// pc_unit_if: control/status bundle between the control FSM and the PC stage.
// master = FSM/debug side (drives controls), slave = pc_unit (drives PC/status).
interface pc_unit_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 pc_control;
  logic                 pc_cond;
  logic [1:0]           orig_pc;
  logic                 bne_or_beq;
  logic                 alu_zero;
  logic [31:0]          alu_result;
  logic [31:0]          alu_out_reg;
  logic [25:0]          instr_index;
  logic                 err_clr;
  logic                 cnt_clr;
  logic [31:0]          pc;
  logic [31:0]          pc_next;
  logic                 branch_taken;
  logic                 misalign_err;
  logic [31:0]          misalign_addr;
  logic [CNT_WIDTH-1:0] br_taken_cnt;
  logic [CNT_WIDTH-1:0] br_ntaken_cnt;
  logic [CNT_WIDTH-1:0] jump_cnt;

  modport master (
    output pc_control, pc_cond, orig_pc,
    output bne_or_beq, alu_zero,
    output alu_result, alu_out_reg,
    output instr_index, err_clr, cnt_clr,
    input  pc, pc_next, branch_taken,
    input  misalign_err, misalign_addr,
    input  br_taken_cnt, br_ntaken_cnt,
    input  jump_cnt
  );

  modport slave (
    input  pc_control, pc_cond, orig_pc,
    input  bne_or_beq, alu_zero,
    input  alu_result, alu_out_reg,
    input  instr_index, err_clr, cnt_clr,
    output pc, pc_next, branch_taken,
    output misalign_err, misalign_addr,
    output br_taken_cnt, br_ntaken_cnt,
    output jump_cnt
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: multicycle MIPS PC register, beq/bne/j target select,
// misalign trap and saturating branch/jump stats.
// Ports: clk, reset (async, active-high), bus (pc_unit_if.slave):
//  controls pc_control/pc_cond/orig_pc/bne_or_beq, alu_zero/result,
//  alu_out_reg, instr_index, err_clr, cnt_clr; status pc, pc_next,
//  branch_taken, misalign_err/addr, br_taken/br_ntaken/jump counts.
module pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16
) (
  input logic     clk,
  input logic     reset,
  pc_unit_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [31:0]          pcQ;
  logic [31:0]          pcNext;
  logic                 brTakenQ;
  logic                 errQ;
  logic [31:0]          errAddrQ;
  logic [CNT_WIDTH-1:0] takenCntQ;
  logic [CNT_WIDTH-1:0] ntakenCntQ;
  logic [CNT_WIDTH-1:0] jumpCntQ;

  logic taken;
  logic wrReq;
  logic badTgt;
  logic wrOk;
  logic wrBad;
  logic isJump;
  logic incTaken;
  logic incNtaken;
  logic incJump;

  always_comb begin
    pcNext = pcQ;
    unique case (bus.orig_pc)
      2'b00: pcNext = bus.alu_result;
      2'b01: pcNext = bus.alu_out_reg;
      2'b10: pcNext = {pcQ[31:28],
                       bus.instr_index,
                       2'b00};
      2'b11: pcNext = pcQ;
    endcase
  end

  assign taken  = bus.bne_or_beq
                ? bus.alu_zero
                : ~bus.alu_zero;
  assign wrReq  = bus.pc_control
                | (bus.pc_cond & taken);
  assign isJump = (bus.orig_pc == 2'b10);
  assign badTgt = (bus.orig_pc == 2'b11)
                | (pcNext[1:0] != 2'b00);
  assign wrOk   = wrReq & ~badTgt;
  assign wrBad  = wrReq & badTgt;

  // Branch stats only when the FSM is in a
  // pure branch state; pc_control overrides.
  assign incTaken  = ~bus.pc_control
                   & bus.pc_cond
                   & taken & wrOk;
  assign incNtaken = ~bus.pc_control
                   & bus.pc_cond
                   & ~taken;
  assign incJump   = wrOk & isJump;

  function automatic logic [CNT_WIDTH-1:0]
    satInc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcQ      <= RESET_PC;
      brTakenQ <= 1'b0;
    end else begin
      if (wrOk)
        pcQ <= pcNext;
      brTakenQ <= incTaken;
    end
  end

  // A new error in the same cycle as err_clr
  // wins and re-captures the address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errQ     <= 1'b0;
      errAddrQ <= 32'h0;
    end else if (wrBad) begin
      errQ <= 1'b1;
      if (!errQ || bus.err_clr)
        errAddrQ <= pcNext;
    end else if (bus.err_clr) begin
      errQ     <= 1'b0;
      errAddrQ <= 32'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      takenCntQ  <= '0;
      ntakenCntQ <= '0;
      jumpCntQ   <= '0;
    end else if (bus.cnt_clr) begin
      takenCntQ  <= '0;
      ntakenCntQ <= '0;
      jumpCntQ   <= '0;
    end else begin
      if (incTaken)
        takenCntQ <= satInc(takenCntQ);
      if (incNtaken)
        ntakenCntQ <= satInc(ntakenCntQ);
      if (incJump)
        jumpCntQ <= satInc(jumpCntQ);
    end
  end

  assign bus.pc            = pcQ;
  assign bus.pc_next       = pcNext;
  assign bus.branch_taken  = brTakenQ;
  assign bus.misalign_err  = errQ;
  assign bus.misalign_addr = errAddrQ;
  assign bus.br_taken_cnt  = takenCntQ;
  assign bus.br_ntaken_cnt = ntakenCntQ;
  assign bus.jump_cnt      = jumpCntQ;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of pc_unit
// (CNT_WIDTH=4 so saturation is reachable).
module tb_pc_unit;
  localparam int CW = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pc_unit_if #(.CNT_WIDTH(CW)) bus ();

  pc_unit #(
    .RESET_PC (32'h0000_0000),
    .CNT_WIDTH(CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pc_control  = 1'b0;
    bus.pc_cond     = 1'b0;
    bus.orig_pc     = 2'b00;
    bus.bne_or_beq  = 1'b0;
    bus.alu_zero    = 1'b0;
    bus.err_clr     = 1'b0;
    bus.cnt_clr     = 1'b0;
  endtask

  task automatic cnts(input string tag,
                      input int t,
                      input int n,
                      input int j);
    chk({tag, ".tcnt"},
        32'(bus.br_taken_cnt), 32'(t));
    chk({tag, ".ncnt"},
        32'(bus.br_ntaken_cnt), 32'(n));
    chk({tag, ".jcnt"},
        32'(bus.jump_cnt), 32'(j));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle();
    bus.alu_result  = 32'h0;
    bus.alu_out_reg = 32'h0;
    bus.instr_index = 26'h0;
    repeat (2) step();
    chk("rst.pc", bus.pc, 32'h0);
    chk("rst.bt", 32'(bus.branch_taken), 0);
    chk("rst.err", 32'(bus.misalign_err), 0);
    chk("rst.addr", bus.misalign_addr, 0);
    cnts("rst", 0, 0, 0);
    reset = 1'b0;
    step();
    chk("idle.pc", bus.pc, 32'h0);

    // PC+4 write
    bus.pc_control = 1'b1;
    bus.alu_result = 32'h4;
    #1 chk("t1.next", bus.pc_next, 32'h4);
    step();
    chk("t1.pc", bus.pc, 32'h4);
    chk("t1.bt", 32'(bus.branch_taken), 0);

    // beq taken
    idle();
    bus.pc_cond     = 1'b1;
    bus.bne_or_beq  = 1'b1;
    bus.alu_zero    = 1'b1;
    bus.orig_pc     = 2'b01;
    bus.alu_out_reg = 32'h20;
    step();
    chk("t2.pc", bus.pc, 32'h20);
    chk("t2.bt", 32'(bus.branch_taken), 1);
    cnts("t2", 1, 0, 0);
    idle();
    step();
    chk("t2.btoff", 32'(bus.branch_taken), 0);

    // beq not taken
    bus.pc_cond     = 1'b1;
    bus.bne_or_beq  = 1'b1;
    bus.alu_zero    = 1'b0;
    bus.orig_pc     = 2'b01;
    bus.alu_out_reg = 32'h40;
    step();
    chk("t2n.pc", bus.pc, 32'h20);
    chk("t2n.bt", 32'(bus.branch_taken), 0);
    cnts("t2n", 1, 1, 0);

    // bne taken
    bus.bne_or_beq  = 1'b0;
    bus.alu_zero    = 1'b0;
    bus.alu_out_reg = 32'h24;
    step();
    chk("bne.pc", bus.pc, 32'h24);
    chk("bne.bt", 32'(bus.branch_taken), 1);
    cnts("bne", 2, 1, 0);

    // pc_control dominates pc_cond
    idle();
    bus.pc_control  = 1'b1;
    bus.pc_cond     = 1'b1;
    bus.bne_or_beq  = 1'b1;
    bus.alu_zero    = 1'b1;
    bus.orig_pc     = 2'b00;
    bus.alu_result  = 32'h1000_0008;
    step();
    chk("dom.pc", bus.pc, 32'h1000_0008);
    chk("dom.bt", 32'(bus.branch_taken), 0);
    cnts("dom", 2, 1, 0);

    // jump
    idle();
    bus.pc_control  = 1'b1;
    bus.orig_pc     = 2'b10;
    bus.instr_index = 26'h10;
    #1 chk("j.next", bus.pc_next,
           32'h1000_0040);
    step();
    chk("j.pc", bus.pc, 32'h1000_0040);
    cnts("j", 2, 1, 1);

    // misaligned target
    bus.orig_pc     = 2'b01;
    bus.alu_out_reg = 32'h22;
    step();
    chk("m1.pc", bus.pc, 32'h1000_0040);
    chk("m1.err", 32'(bus.misalign_err), 1);
    chk("m1.addr", bus.misalign_addr, 32'h22);
    bus.alu_out_reg = 32'h31;
    step();
    chk("m2.addr", bus.misalign_addr, 32'h22);
    bus.orig_pc = 2'b11;
    step();
    chk("m3.pc", bus.pc, 32'h1000_0040);
    chk("m3.addr", bus.misalign_addr, 32'h22);
    cnts("m3", 2, 1, 1);
    idle();
    bus.err_clr = 1'b1;
    step();
    chk("clr.err", 32'(bus.misalign_err), 0);
    chk("clr.addr", bus.misalign_addr, 0);
    bus.pc_control  = 1'b1;
    bus.orig_pc     = 2'b01;
    bus.alu_out_reg = 32'h36;
    step();
    chk("clrw.err", 32'(bus.misalign_err), 1);
    chk("clrw.addr", bus.misalign_addr, 32'h36);
    idle();
    bus.err_clr = 1'b1;
    step();
    chk("clr2.err", 32'(bus.misalign_err), 0);

    // saturation: 2 + 16 taken branches
    idle();
    bus.pc_cond     = 1'b1;
    bus.bne_or_beq  = 1'b1;
    bus.alu_zero    = 1'b1;
    bus.orig_pc     = 2'b01;
    bus.alu_out_reg = 32'h100;
    repeat (16) step();
    chk("sat.tcnt",
        32'(bus.br_taken_cnt), 32'hF);
    step();
    chk("sat2.tcnt",
        32'(bus.br_taken_cnt), 32'hF);
    bus.cnt_clr = 1'b1;
    step();
    cnts("cclr", 0, 0, 0);
    chk("cclr.pc", bus.pc, 32'h100);

    // reset mid-branch
    idle();
    bus.pc_control  = 1'b1;
    bus.orig_pc     = 2'b10;
    bus.instr_index = 26'h40;
    step();
    chk("j2.pc", bus.pc, 32'h0000_0100);
    idle();
    bus.pc_cond     = 1'b1;
    bus.bne_or_beq  = 1'b1;
    bus.alu_zero    = 1'b1;
    bus.orig_pc     = 2'b01;
    bus.alu_out_reg = 32'h200;
    step();
    chk("pre.bt", 32'(bus.branch_taken), 1);
    cnts("pre", 1, 0, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar.pc", bus.pc, 32'h0);
    chk("ar.bt", 32'(bus.branch_taken), 0);
    cnts("ar", 0, 0, 0);
    step();
    reset = 1'b0;
    idle();
    step();
    chk("post.pc", bus.pc, 32'h0);
    chk("post.bt", 32'(bus.branch_taken), 0);
    cnts("post", 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
